// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the PC, issues credit-limited word requests, tags responses
// in order and buffers them for decode. Optional misaligned-redirect halt: FETCH_MISALIGN_CHK_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic        fetch_misaligned_o,
`endif
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic [31:0] inst_pc_next_o
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_ent_t;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, tag_wr_q, tag_rd_q;
  fetch_ent_t    fifo_q [FIFO_DEPTH];
  logic [31:0]   tag_q  [FIFO_DEPTH];
  logic          run, req_fire, rsp_drop, push, pop;
  logic [CW:0]   credit;
  logic [31:0]   target;

`ifdef FETCH_MISALIGN_CHK_EN
  typedef enum logic {RUN, HALT} state_e;
  state_e state_q;
  logic   misaligned_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RUN;
      misaligned_q <= 1'b0;
    end else if (redirect_i) begin
      if (redirect_pc_i[1:0] != 2'b00) begin
        state_q      <= HALT;
        misaligned_q <= 1'b1;
      end else begin
        state_q      <= RUN;
        misaligned_q <= 1'b0;
      end
    end
  end

  assign run                = (state_q == RUN);
  assign fetch_misaligned_o = misaligned_q;
  assign target             = redirect_pc_i;
`else
  assign run    = 1'b1;
  assign target = redirect_pc_i & ~32'd3;
`endif

  // Credit counts in-flight requests plus buffered entries, so every response has a slot.
  // Reset gating keeps the request port quiet while the block is held in reset.
  assign pop              = inst_valid_o & inst_ready_i;
  assign credit           = {1'b0, outst_q} + {1'b0, cnt_q} - {{CW{1'b0}}, pop};
  assign imem_req_valid_o = rst_ni & run & ~redirect_i & (credit < DEPTH_C);
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o & imem_req_ready_i;

  // A response coinciding with a redirect is counted as dropped, not discarded later.
  assign rsp_drop     = imem_rsp_valid_i & ((disc_q != '0) | redirect_i);
  assign push         = imem_rsp_valid_i & ~rsp_drop;
  assign inst_valid_o = (cnt_q != '0) & ~redirect_i;

  always_comb begin
    outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
    disc_d  = disc_q;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    wr_d    = wr_q + PW'(push);
    rd_d    = rd_q + PW'(pop);
    pc_d    = req_fire ? pc_q + 32'd4 : pc_q;
    if (imem_rsp_valid_i && disc_q != '0) disc_d = disc_q - CW'(1);
    if (redirect_i) begin
      cnt_d  = '0;
      wr_d   = wr_q;
      rd_d   = wr_q;
      disc_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
      pc_d   = target;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= RESET_PC;
      outst_q  <= '0;
      disc_q   <= '0;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      pc_q     <= pc_d;
      outst_q  <= outst_d;
      disc_q   <= disc_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      tag_wr_q <= tag_wr_q + PW'(req_fire);
      tag_rd_q <= tag_rd_q + PW'(imem_rsp_valid_i);
    end
  end

  // Tag queue pops on every response, dropped or not, so it stays aligned with memory order.
  always_ff @(posedge clk_i) begin
    if (req_fire) tag_q[tag_wr_q] <= pc_q;
    if (push)     fifo_q[wr_q]    <= '{inst: imem_rsp_data_i, pc: tag_q[tag_rd_q]};
  end

  assign inst_o         = fifo_q[rd_q].inst;
  assign inst_pc_o      = fifo_q[rd_q].pc;
  assign inst_pc_next_o = inst_pc_o + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural in-order memory with variable latency,
// decode-side pop log, hand-computed expected addresses/PCs/words.
module tb_fetch_stage;
  logic        clk, rst_n;
  logic        req_valid, req_ready, rsp_valid, redirect, inst_valid, inst_ready;
  logic [31:0] addr, rsp_data, redirect_pc, inst, inst_pc, inst_pc_next;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misaligned;
`endif

  int checks = 0;
  int failures = 0;
  int mem_lat = 1;
  int cyc = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t       mq[$];
  logic        m_fire;
  logic [31:0] m_addr;
  logic [31:0] log_pc[$];
  logic [31:0] log_inst[$];

  fetch_stage #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready), .imem_req_addr_o(addr),
    .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
`ifdef FETCH_MISALIGN_CHK_EN
    .fetch_misaligned_o(misaligned),
`endif
    .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
    .inst_o(inst), .inst_pc_o(inst_pc), .inst_pc_next_o(inst_pc_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: word at address A reads as {A[15:0], 16'hC0DE}; response mem_lat cycles after accept.
  always begin
    @(negedge clk); #3;
    m_fire = rst_n && req_valid && req_ready;
    m_addr = addr;
    @(posedge clk); #1;
    cyc++;
    if (!rst_n) mq.delete();
    else begin
      if (rsp_valid) void'(mq.pop_front());
      if (m_fire) mq.push_back('{m_addr, cyc + mem_lat - 1});
    end
    if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
      mreq_t h;
      h = mq[0];
      rsp_valid = 1'b1;
      rsp_data  = {h.addr[15:0], 16'hC0DE};
    end else begin
      rsp_valid = 1'b0;
    end
  end

  always begin
    @(negedge clk); #3;
    if (rst_n && inst_valid && inst_ready) begin
      log_pc.push_back(inst_pc);
      log_inst.push_back(inst);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk); #1;
  endtask

  task automatic do_reset(input int lat);
    @(negedge clk);
    rst_n = 1'b0; redirect = 1'b0; req_ready = 1'b1; inst_ready = 1'b1; mem_lat = lat;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_addr", addr, 32'h100);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("rst_misaligned", 32'(misaligned), 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1; #1;
  endtask

  initial begin
    rst_n = 1'b0; req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;

    // Streaming from reset, 1-cycle memory
    do_reset(1);
    log_pc.delete(); log_inst.delete();
    chk("t1_c0_req_valid", 32'(req_valid), 32'd1);
    chk("t1_c0_addr", addr, 32'h100);
    chk("t1_c0_inst_valid", 32'(inst_valid), 32'd0);
    nxt();
    chk("t1_c1_addr", addr, 32'h104);
    chk("t1_c1_inst_valid", 32'(inst_valid), 32'd0);
    nxt();
    chk("t1_c2_inst_valid", 32'(inst_valid), 32'd1);
    chk("t1_c2_inst_pc", inst_pc, 32'h100);
    chk("t1_c2_inst", inst, 32'h0100_C0DE);
    chk("t1_c2_pc_next", inst_pc_next, 32'h104);
    chk("t1_c2_addr", addr, 32'h108);
    nxt();
    chk("t1_c3_inst_pc", inst_pc, 32'h104);
    chk("t1_c3_addr", addr, 32'h10C);

    // Decode stall for 10 cycles
    @(negedge clk); inst_ready = 1'b0; #1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) nxt();
      chk("t2_stall_req_valid", 32'(req_valid), 32'd0);
      chk("t2_stall_inst_pc", inst_pc, 32'h108);
    end
    @(negedge clk); inst_ready = 1'b1; #1;
    chk("t2_rel_inst_pc", inst_pc, 32'h108);
    chk("t2_rel_req_valid", 32'(req_valid), 32'd1);
    chk("t2_rel_addr", addr, 32'h110);
    nxt();
    chk("t2_c15_inst_pc", inst_pc, 32'h10C);
    nxt();
    chk("t2_c16_inst_pc", inst_pc, 32'h110);
    chk("t2_c16_inst_valid", 32'(inst_valid), 32'd1);
    nxt();
    chk("t2_log_size", 32'(log_pc.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < log_pc.size()) begin
        logic [31:0] ep;
        ep = 32'h100 + 32'(4 * i);
        chk("t2_log_pc", log_pc[i], ep);
        chk("t2_log_inst", log_inst[i], {ep[15:0], 16'hC0DE});
      end
    end

    // Memory request back-pressure holds the address
    do_reset(1);
    nxt(); nxt();
    @(negedge clk); req_ready = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) nxt();
      chk("t5_hold_addr", addr, 32'h10C);
      chk("t5_hold_valid", 32'(req_valid), 32'd1);
    end
    @(negedge clk); req_ready = 1'b1; #1;
    chk("t5_rel_addr", addr, 32'h10C);
    nxt();
    chk("t5_adv_addr", addr, 32'h110);
    nxt();
    chk("t5_inst_pc", inst_pc, 32'h10C);
    chk("t5_inst", inst, 32'h010C_C0DE);

    // 3-cycle memory, redirect with two requests in flight
    do_reset(3);
    chk("t3_c0_addr", addr, 32'h100);
    nxt();
    chk("t3_c1_addr", addr, 32'h104);
    chk("t3_c1_req_valid", 32'(req_valid), 32'd1);
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h200; #1;
    chk("t3_redir_req_valid", 32'(req_valid), 32'd0);
    @(negedge clk); redirect = 1'b0; #1;
    chk("t3_c3_req_valid", 32'(req_valid), 32'd0);
    chk("t3_c3_addr", addr, 32'h200);
    chk("t3_c3_inst_valid", 32'(inst_valid), 32'd0);
    nxt();
    chk("t3_c4_req_valid", 32'(req_valid), 32'd1);
    chk("t3_c4_inst_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("t3_wait_inst_valid", 32'(inst_valid), 32'd0);
    end
    nxt();
    chk("t3_inst_valid", 32'(inst_valid), 32'd1);
    chk("t3_inst_pc", inst_pc, 32'h200);
    chk("t3_inst", inst, 32'h0200_C0DE);

    // Redirect coinciding with a response and a ready decode
    do_reset(1);
    nxt(); nxt();
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h300; #1;
    chk("t4_redir_inst_valid", 32'(inst_valid), 32'd0);
    chk("t4_redir_req_valid", 32'(req_valid), 32'd0);
    @(negedge clk); redirect = 1'b0; #1;
    chk("t4_c4_inst_valid", 32'(inst_valid), 32'd0);
    chk("t4_c4_addr", addr, 32'h300);
    chk("t4_c4_req_valid", 32'(req_valid), 32'd1);
    nxt();
    chk("t4_c5_inst_valid", 32'(inst_valid), 32'd0);
    nxt();
    chk("t4_c6_inst_valid", 32'(inst_valid), 32'd1);
    chk("t4_c6_inst_pc", inst_pc, 32'h300);
    chk("t4_c6_inst", inst, 32'h0300_C0DE);
    chk("t4_c6_pc_next", inst_pc_next, 32'h304);

    // PC wrap at the top of the address space
    do_reset(1);
    nxt(); nxt();
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; #1;
    @(negedge clk); redirect = 1'b0; #1;
    chk("t7_addr_f8", addr, 32'hFFFF_FFF8);
    nxt();
    chk("t7_addr_fc", addr, 32'hFFFF_FFFC);
    nxt();
    chk("t7_addr_wrap", addr, 32'h0);
    chk("t7_inst_pc_f8", inst_pc, 32'hFFFF_FFF8);
    nxt();
    chk("t7_inst_pc_fc", inst_pc, 32'hFFFF_FFFC);
    chk("t7_pc_next_wrap", inst_pc_next, 32'h0);
    chk("t7_inst_fc", inst, 32'hFFFC_C0DE);

    // Misaligned redirect target
    do_reset(1);
    nxt(); nxt();
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h202; #1;
    @(negedge clk); redirect = 1'b0; #1;
`ifdef FETCH_MISALIGN_CHK_EN
    chk("t6_misaligned_set", 32'(misaligned), 32'd1);
    chk("t6_halt_req_valid", 32'(req_valid), 32'd0);
    chk("t6_halt_addr", addr, 32'h202);
    nxt();
    chk("t6_halt_req_valid2", 32'(req_valid), 32'd0);
    chk("t6_halt_inst_valid", 32'(inst_valid), 32'd0);
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h300; #1;
    @(negedge clk); redirect = 1'b0; #1;
    chk("t6_misaligned_clr", 32'(misaligned), 32'd0);
    chk("t6_run_req_valid", 32'(req_valid), 32'd1);
    chk("t6_run_addr", addr, 32'h300);
    nxt(); nxt();
    chk("t6_inst_pc", inst_pc, 32'h300);
    chk("t6_inst", inst, 32'h0300_C0DE);
`else
    chk("t6_req_valid", 32'(req_valid), 32'd1);
    chk("t6_addr", addr, 32'h200);
    nxt(); nxt();
    chk("t6_inst_valid", 32'(inst_valid), 32'd1);
    chk("t6_inst_pc", inst_pc, 32'h200);
    chk("t6_inst", inst, 32'h0200_C0DE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
